// File: rtl/inv_chk_pkg.sv
// Shared types and default sizing for the NMOS inverter stimulus/check stage.
// Holds the FSM state encoding, the vector-table entry layout and a state decode helper.
package inv_chk_pkg;

  localparam int DEF_NUM_VEC    = 16;
  localparam int DEF_IDX_W      = 4;
  localparam int DEF_SETTLE_CYC = 2;
  localparam int DEF_CNT_W      = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Entry layout matches the write port: {expected_out, stimulus_in}.
  typedef struct packed {
    logic exp;
    logic stim;
  } vec_t;

  function automatic logic state_is_busy(input state_e s);
    case (s)
      ST_DRIVE, ST_SETTLE, ST_SAMPLE: state_is_busy = 1'b1;
      default:                        state_is_busy = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/inv_vec_table.sv
// Vector register file: synchronous write, combinational read.
// Writes are refused while a run is in progress so a run sees a stable table.
module inv_vec_table
  import inv_chk_pkg::*;
#(
  parameter int NUM_VEC = DEF_NUM_VEC,
  parameter int IDX_W   = DEF_IDX_W
) (
  input  logic             i_clk,
  input  logic             i_busy,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_addr,
  input  logic [1:0]       i_wr_data,
  input  logic [IDX_W-1:0] i_rd_addr,
  output logic [1:0]       o_rd_data
);

  vec_t r_mem [NUM_VEC];
  logic w_wr_ok;

  assign w_wr_ok = i_wr_en && !i_busy && (32'(i_wr_addr) < NUM_VEC);

  // Table contents deliberately survive reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok) begin
      r_mem[i_wr_addr] <= vec_t'(i_wr_data);
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/inv_stim_checker.sv
// Drives the inverter input from the vector table, samples its output after a
// programmable settle time and keeps pass/fail counts plus the first failing index.
module inv_stim_checker
  import inv_chk_pkg::*;
#(
  parameter int NUM_VEC    = DEF_NUM_VEC,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_addr,
  input  logic [1:0]       i_wr_data,
  input  logic             i_start,
  output logic             o_dut_in,
  input  logic             i_dut_out,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_pass_cnt,
  output logic [CNT_W-1:0] o_fail_cnt,
  output logic             o_first_fail_vld,
  output logic [IDX_W-1:0] o_first_fail_idx
);

  localparam int               SET_W    = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'(SETTLE_CYC - 1);
  localparam logic [SET_W-1:0] SET_ZERO = SET_W'(1'b0);
  localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1'b1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(1'b0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(1'b0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_e           r_state;
  state_e           w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  logic [SET_W-1:0] r_set_cnt;
  logic             r_dut_in;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_pass_cnt;
  logic [CNT_W-1:0] r_fail_cnt;
  logic             r_ff_vld;
  logic [IDX_W-1:0] r_ff_idx;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [1:0]       w_rd_data;
  vec_t             w_rd_vec;
  logic             w_match;

  // The write port is gated by the registered busy flag, so a write that
  // coincides with start lands on the start edge and vector 0 reads it next cycle.
  inv_vec_table #(
    .NUM_VEC (NUM_VEC),
    .IDX_W   (IDX_W)
  ) u_table (
    .i_clk     (i_clk),
    .i_busy    (r_busy),
    .i_wr_en   (i_wr_en),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .i_rd_addr (r_idx),
    .o_rd_data (w_rd_data)
  );

  assign w_rd_vec = vec_t'(w_rd_data);
  // Case equality so an X or Z on the inverter output always counts as a fail.
  assign w_match  = (i_dut_out === w_rd_vec.exp);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) w_state_nxt = ST_DRIVE;
        else         w_state_nxt = r_state;
      end
      ST_DRIVE:  w_state_nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (r_set_cnt == SET_ZERO) w_state_nxt = ST_SAMPLE;
        else                       w_state_nxt = ST_SETTLE;
      end
      ST_SAMPLE: begin
        if (r_idx == IDX_LAST) w_state_nxt = ST_DONE;
        else                   w_state_nxt = ST_DRIVE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state, then registered.
  always_comb begin
    w_busy_nxt = state_is_busy(w_state_nxt);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  // Registered status flags.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Datapath: vector index, settle timer, stimulus drive and scoreboard.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_idx      <= IDX_ZERO;
      r_set_cnt  <= SET_ZERO;
      r_dut_in   <= 1'b0;
      r_pass_cnt <= CNT_ZERO;
      r_fail_cnt <= CNT_ZERO;
      r_ff_vld   <= 1'b0;
      r_ff_idx   <= IDX_ZERO;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_idx      <= IDX_ZERO;
            r_pass_cnt <= CNT_ZERO;
            r_fail_cnt <= CNT_ZERO;
            r_ff_vld   <= 1'b0;
            r_ff_idx   <= IDX_ZERO;
          end
        end
        ST_DRIVE: begin
          r_dut_in  <= w_rd_vec.stim;
          r_set_cnt <= SET_LOAD;
        end
        ST_SETTLE: begin
          if (r_set_cnt != SET_ZERO) r_set_cnt <= r_set_cnt - SET_ONE;
        end
        ST_SAMPLE: begin
          if (w_match) begin
            if (r_pass_cnt != CNT_MAX) r_pass_cnt <= r_pass_cnt + CNT_ONE;
          end else begin
            if (r_fail_cnt != CNT_MAX) r_fail_cnt <= r_fail_cnt + CNT_ONE;
            if (!r_ff_vld) begin
              r_ff_vld <= 1'b1;
              r_ff_idx <= r_idx;
            end
          end
          if (r_idx != IDX_LAST) r_idx <= r_idx + IDX_ONE;
        end
        default: begin
          r_idx <= IDX_ZERO;
        end
      endcase
    end
  end

  assign o_dut_in         = r_dut_in;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_pass_cnt       = r_pass_cnt;
  assign o_fail_cnt       = r_fail_cnt;
  assign o_first_fail_vld = r_ff_vld;
  assign o_first_fail_idx = r_ff_idx;

endmodule

// File: tb/tb_inv_stim_checker.sv
// Bench for inv_stim_checker: three instances (default sizing, short run, narrow counters)
// checked against a vector-level reference model of the run result.
module tb_inv_stim_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_bc;
  logic [2:0] start_v, wr_en_v;
  logic [3:0] wr_addr;
  logic [1:0] wr_data;
  logic       xmode, xv;

  logic       din_a, dout_a, busy_a, done_a, ffv_a;
  logic [7:0] pass_a, fail_a;
  logic [3:0] ffi_a;
  logic       din_b, busy_b, done_b, ffv_b;
  logic [7:0] pass_b, fail_b;
  logic [0:0] ffi_b;
  logic       din_c, busy_c, done_c, ffv_c;
  logic [1:0] pass_c, fail_c;
  logic [3:0] ffi_c;

  assign dout_a = xmode ? xv : ~din_a;

  inv_stim_checker #(.NUM_VEC(16), .IDX_W(4), .SETTLE_CYC(2), .CNT_W(8)) u_a (
    .i_clk(clk), .i_rst_n(rst_a), .i_wr_en(wr_en_v[0]), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_start(start_v[0]), .o_dut_in(din_a), .i_dut_out(dout_a),
    .o_busy(busy_a), .o_done(done_a), .o_pass_cnt(pass_a), .o_fail_cnt(fail_a),
    .o_first_fail_vld(ffv_a), .o_first_fail_idx(ffi_a));

  inv_stim_checker #(.NUM_VEC(2), .IDX_W(1), .SETTLE_CYC(1), .CNT_W(8)) u_b (
    .i_clk(clk), .i_rst_n(rst_bc), .i_wr_en(wr_en_v[1]), .i_wr_addr(wr_addr[0:0]),
    .i_wr_data(wr_data), .i_start(start_v[1]), .o_dut_in(din_b), .i_dut_out(~din_b),
    .o_busy(busy_b), .o_done(done_b), .o_pass_cnt(pass_b), .o_fail_cnt(fail_b),
    .o_first_fail_vld(ffv_b), .o_first_fail_idx(ffi_b));

  inv_stim_checker #(.NUM_VEC(16), .IDX_W(4), .SETTLE_CYC(1), .CNT_W(2)) u_c (
    .i_clk(clk), .i_rst_n(rst_bc), .i_wr_en(wr_en_v[2]), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .i_start(start_v[2]), .o_dut_in(din_c), .i_dut_out(~din_c),
    .o_busy(busy_c), .o_done(done_c), .o_pass_cnt(pass_c), .o_fail_cnt(fail_c),
    .o_first_fail_vld(ffv_c), .o_first_fail_idx(ffi_c));

  // Observation mux so one run task can serve every instance.
  int          cur;
  logic        o_busy, o_done, o_din, o_ffv;
  logic [31:0] o_pass, o_fail, o_ffi;
  always_comb begin
    case (cur)
      1: begin
        o_busy = busy_b; o_done = done_b; o_din = din_b; o_ffv = ffv_b;
        o_pass = 32'(pass_b); o_fail = 32'(fail_b); o_ffi = 32'(ffi_b);
      end
      2: begin
        o_busy = busy_c; o_done = done_c; o_din = din_c; o_ffv = ffv_c;
        o_pass = 32'(pass_c); o_fail = 32'(fail_c); o_ffi = 32'(ffi_c);
      end
      default: begin
        o_busy = busy_a; o_done = done_a; o_din = din_a; o_ffv = ffv_a;
        o_pass = 32'(pass_a); o_fail = 32'(fail_a); o_ffi = 32'(ffi_a);
      end
    endcase
  end

  int   n_chk = 0;
  int   n_err = 0;
  logic m_stim [16];
  logic m_exp  [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int sel, input int idx, input logic s, input logic e);
    wr_en_v[sel] = 1'b1;
    wr_addr      = 4'(idx);
    wr_data      = {e, s};
    @(posedge clk); #1;
    wr_en_v[sel] = 1'b0;
    m_stim[idx]  = s;
    m_exp[idx]   = e;
  endtask

  // Reference: each vector passes when the observed inverter output is a known
  // value equal to its expected bit; counts clip at the counter's maximum.
  task automatic model(input int nv, input int cw, input logic xm,
                       output int ep, output int ef, output logic ev, output int ei);
    logic o;
    int   mx;
    ep = 0; ef = 0; ev = 1'b0; ei = 0;
    for (int i = 0; i < nv; i++) begin
      o = xm ? xv : ~m_stim[i];
      if (!$isunknown(o) && (o === m_exp[i])) ep++;
      else begin
        ef++;
        if (!ev) begin ev = 1'b1; ei = i; end
      end
    end
    mx = (1 << cw) - 1;
    if (ep > mx) ep = mx;
    if (ef > mx) ef = mx;
  endtask

  task automatic do_run(input int sel, input string tag, input int nv, input int sc,
                        input int cw, input logic xm, input int inj, input int rst_at);
    int   k, ep, ef, ei;
    logic ev, aborted;
    start_v[sel] = 1'b1;
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    wr_en_v[sel] = 1'b0;
    chk({tag, "_busy_start"}, 32'(o_busy), 32'd1);
    k = 0;
    aborted = 1'b0;
    while (!o_done && !aborted && k < 4096) begin
      if (k == inj) begin
        start_v[sel] = 1'b1; wr_en_v[sel] = 1'b1; wr_addr = 4'd12; wr_data = 2'b00;
      end
      if (k == rst_at) rst_a = 1'b0;
      @(posedge clk); #1;
      k++;
      start_v[sel] = 1'b0;
      wr_en_v[sel] = 1'b0;
      if (!rst_a) begin rst_a = 1'b1; aborted = 1'b1; end
    end
    if (aborted) begin
      chk({tag, "_rst_busy"}, 32'(o_busy), 32'd0);
      chk({tag, "_rst_done"}, 32'(o_done), 32'd0);
      chk({tag, "_rst_pass"}, o_pass, 32'd0);
      chk({tag, "_rst_fail"}, o_fail, 32'd0);
      chk({tag, "_rst_ffv"},  32'(o_ffv), 32'd0);
      chk({tag, "_rst_din"},  32'(o_din), 32'd0);
      return;
    end
    model(nv, cw, xm, ep, ef, ev, ei);
    chk({tag, "_cycles"}, 32'(k), 32'(nv * (sc + 2)));
    chk({tag, "_pass"}, o_pass, 32'(ep));
    chk({tag, "_fail"}, o_fail, 32'(ef));
    chk({tag, "_ffv"},  32'(o_ffv), 32'(ev));
    chk({tag, "_ffi"},  o_ffi, 32'(ei));
    chk({tag, "_busy_end"}, 32'(o_busy), 32'd0);
    chk({tag, "_din_hold"}, 32'(o_din), 32'(m_stim[nv-1]));
    @(posedge clk); #1;
    chk({tag, "_done_held"}, 32'(o_done), 32'd1);
  endtask

  initial begin
    cur = 0; xmode = 1'b0; xv = 1'bx;
    rst_a = 1'b0; rst_bc = 1'b0; start_v = 3'b000; wr_en_v = 3'b000;
    wr_addr = 4'd0; wr_data = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b1; rst_bc = 1'b1;
    chk("reset_busy", 32'(busy_a), 32'd0);
    chk("reset_done", 32'(done_a), 32'd0);
    chk("reset_din",  32'(din_a),  32'd0);
    chk("reset_pass", 32'(pass_a), 32'd0);
    chk("reset_fail", 32'(fail_a), 32'd0);
    chk("reset_ffv",  32'(ffv_a),  32'd0);
    chk("reset_ffi",  32'(ffi_a),  32'd0);

    for (int i = 0; i < 16; i++) load(0, i, 1'(i % 2), ~1'(i % 2));
    do_run(0, "base", 16, 2, 8, 1'b0, -1, -1);

    load(0, 5, 1'b1, 1'b1);
    do_run(0, "fail5", 16, 2, 8, 1'b0, -1, -1);
    load(0, 5, 1'b1, 1'b0);

    xmode = 1'b1;
    do_run(0, "xout", 16, 2, 8, 1'b1, -1, -1);
    xmode = 1'b0;

    do_run(0, "midrun", 16, 2, 8, 1'b0, 10, -1);
    do_run(0, "after_mid", 16, 2, 8, 1'b0, -1, -1);

    do_run(0, "rst_v7", 16, 2, 8, 1'b0, -1, 29);
    do_run(0, "post_rst", 16, 2, 8, 1'b0, -1, -1);

    // Write to vector 0 in the start cycle; the run must see the new entry.
    wr_en_v[0] = 1'b1; wr_addr = 4'd0; wr_data = 2'b00;
    m_stim[0] = 1'b0; m_exp[0] = 1'b0;
    do_run(0, "wr_start", 16, 2, 8, 1'b0, -1, -1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) load(0, i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      do_run(0, $sformatf("rand%0d", r), 16, 2, 8, 1'b0, -1, -1);
    end

    cur = 1;
    load(1, 0, 1'b1, 1'b0);
    load(1, 1, 1'b0, 1'b0);
    do_run(1, "short", 2, 1, 8, 1'b0, -1, -1);

    cur = 2;
    for (int i = 0; i < 16; i++) load(2, i, 1'(i % 2), ~1'(i % 2));
    do_run(2, "sat_pass", 16, 1, 2, 1'b0, -1, -1);
    for (int i = 0; i < 16; i++) load(2, i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    do_run(2, "sat_rand", 16, 1, 2, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
